// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

    // Top-level control states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_word_serializer_shift.sv
// Word-wide shift register with bit counter and first/last flags.
// A load takes priority over a shift; the counter restarts at zero on load.
module ser_shift_reg
    import fifo_ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             first,
    output logic             last
);

    localparam int CW = cnt_w(WIDTH);
    // Explicit terminal count so non-power-of-two widths never rely on wrap.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    // Right-shift by one with zero fill; the LSB is always the bit on the wire.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shifted[gi] = shreg_q[gi + 1];
        end
    endgenerate
    assign shifted[WIDTH-1] = 1'b0;

    // Next-state selection: load a fresh word, advance one bit, or hold.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = load_data;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // Register update with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_out = shreg_q[0];
    assign first   = (bit_cnt_q == '0);
    assign last    = (bit_cnt_q == LAST_CNT);

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a show-ahead FIFO and streams them LSB-first as a
// one-bit valid/ready stream, chaining words with no bubble cycles.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int width    = 8,
    parameter int cnt_bits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [width-1:0]    fifo_rdata,
    output logic                fifo_read,
    output logic                s_valid,
    input  logic                s_ready,
    output logic                s_bit,
    output logic                s_first,
    output logic                s_last,
    output logic                busy,
    output logic [cnt_bits-1:0] words_sent
);

    ser_state_t          state_q, state_d;
    logic [cnt_bits-1:0] words_sent_q, words_sent_d;
    // Remembers that reset was high last cycle, so outputs (including the
    // pop strobe) stay quiet for one cycle after reset is released.
    logic                hold_q, hold_d;

    logic pop_ok;
    logic active;
    logic load;
    logic shift_en;
    logic sr_bit, sr_first, sr_last;

    ser_shift_reg #(
        .WIDTH (width)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (fifo_rdata),
        .shift_en  (shift_en),
        .bit_out   (sr_bit),
        .first     (sr_first),
        .last      (sr_last)
    );

    assign pop_ok = enable & ~fifo_empty & ~hold_q & ~reset;
    assign hold_d = reset;

    // FSM next state, pop strobe and shift control; a new word may only be
    // popped from IDLE or on the transfer of the final bit of a word.
    always_comb begin
        state_d      = state_q;
        words_sent_d = words_sent_q;
        fifo_read    = 1'b0;
        load         = 1'b0;
        shift_en     = 1'b0;
        active       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop_ok) begin
                    fifo_read = 1'b1;
                    load      = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                active = ~reset;
                if (active && s_ready) begin
                    if (!sr_last) begin
                        shift_en = 1'b1;
                    end else begin
                        words_sent_d = words_sent_q + cnt_bits'(1);
                        if (pop_ok) begin
                            fifo_read = 1'b1;
                            load      = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // State, counter and post-reset hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            words_sent_q <= '0;
            hold_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            words_sent_q <= words_sent_d;
            hold_q       <= hold_d;
        end
    end

    assign s_valid    = active;
    assign busy       = active;
    assign s_bit      = active & sr_bit;
    assign s_first    = active & sr_first;
    assign s_last     = active & sr_last;
    assign words_sent = reset ? '0 : words_sent_q;

endmodule
